vdp_video_timing: RTL and testbench
===================================

Name: vdp_video_timing

Overview:
- Parametrised raster timing generator and RGB blanker for the VDP video path.
- Sits between the VDP core's colour outputs and the board video DAC/scaler. It regenerates clean HS/VS/blank from its own H/V counters.
- Generalises the fixed-count test timing into programmable totals, sync widths and sync polarity, an integer pixel divider, and a runtime NTSC/PAL line count.
- Adds line/frame strobes and counter outputs for downstream scalers and OSD.

Parameters:
- CLK_DIV, 2: number of ena cycles per pixel (1..16).
- H_TOTAL, 342: pixels per line (counter range 0..H_TOTAL-1).
- H_INIT, 306: hcnt value loaded at reset (phase alignment to the VDP core; 0..H_TOTAL-1).
- H_SYNC, 20: hsync is active while hcnt < H_SYNC.
- H_ACT_START, 60: first visible pixel.
- H_ACT_END, 341: first non-visible pixel after the active region.
- V_TOTAL_NTSC, 262: lines per frame when NTSC is selected.
- V_TOTAL_PAL, 313: lines per frame when PAL is selected.
- V_SYNC, 4: vsync is active while vcnt < V_SYNC.
- V_BLANK, 8: lines with vcnt < V_BLANK are blanked.
- HS_POL, 0: active level of HS (0 = active-low).
- VS_POL, 0: active level of VS (0 = active-low).
- COLOR_W, 6: width of each colour channel.

Ports:
- clk  in  1  system clock.
- RESET  in  1  synchronous reset, active-high.
- ena  in  1  clock enable, the 10.7 MHz domain strobe.
- pal  in  1  1 = PAL line count, 0 = NTSC.
- r_i  in  COLOR_W  red from the VDP core.
- g_i  in  COLOR_W  green from the VDP core.
- b_i  in  COLOR_W  blue from the VDP core.
- HS  out  1  horizontal sync.
- VS  out  1  vertical sync.
- blank  out  1  1 = outside the active area.
- R  out  COLOR_W  blanked red.
- G  out  COLOR_W  blanked green.
- B  out  COLOR_W  blanked blue.
- line_start  out  1  one-clk strobe when hcnt wraps.
- frame_start  out  1  one-clk strobe when vcnt wraps.
- hcnt_o  out  10  current pixel count.
- vcnt_o  out  10  current line count.

Behaviour:
- All state changes on the rising edge of clk. RESET has priority over ena and is honoured on any cycle, including mid-line and mid-frame.
- Reset values:
  - div=0, hcnt=H_INIT, vcnt=0.
  - pal_q=pal (sampled during reset).
  - HS=~HS_POL, VS=~VS_POL, blank=1.
  - R=G=B=0, line_start=0, frame_start=0.
- Divider:
  - When ena=1, div increments.
  - tick = ena & (div==CLK_DIV-1); div returns to 0 on tick.
  - CLK_DIV=1 gives tick=ena.
  - ena=0 freezes div, hcnt and vcnt.
- Horizontal, on tick:
  - If hcnt==H_TOTAL-1: hcnt<=0 and a line wrap occurs.
  - Otherwise hcnt<=hcnt+1.
- Vertical, on line wrap:
  - vtot = pal_q ? V_TOTAL_PAL : V_TOTAL_NTSC.
  - If vcnt==vtot-1: vcnt<=0, pal_q<=pal, and a frame wrap occurs.
  - Otherwise vcnt<=vcnt+1.
  - A pal change mid-frame takes effect only at the next frame wrap, so a frame never has a mixed line count.
- Outputs are registered every clk (not gated by ena) from the current counters. Latency is one clk after a counter change.
  - HS = (hcnt < H_SYNC) ? HS_POL : ~HS_POL.
  - VS = (vcnt < V_SYNC) ? VS_POL : ~VS_POL.
  - blank = (vcnt < V_BLANK) | (hcnt < H_ACT_START) | (hcnt >= H_ACT_END).
  - R/G/B = blank_comb ? 0 : r_i/g_i/b_i. This uses the same-cycle comb blank, so colour and blank are aligned.
- Strobes:
  - line_start = 1 for exactly one clk, the clk after a tick that wrapped hcnt.
  - frame_start = 1 for exactly one clk, coincident with line_start on a frame wrap.
- hcnt_o/vcnt_o are the counter registers, zero-extended to 10 bits.
- Width rule: all compares are unsigned 10-bit. No counter ever exceeds H_TOTAL-1 or V_TOTAL_PAL-1.
- Parameter legality, checked at elaboration with assertion/$error:
  - H_SYNC < H_ACT_START < H_ACT_END <= H_TOTAL <= 1024.
  - V_SYNC <= V_BLANK < min(V_TOTAL_*).
  - H_INIT < H_TOTAL.

Test Plan:
1. Defaults, ena=1 constant, RESET 3 clks then release:
   - hcnt_o=306 at release.
   - hcnt advances every 2 clks.
   - First line_start occurs 36 pixel ticks (72 clks) after release, with vcnt_o=1 after it.
   - HS is low for exactly 40 clks per line (20 ticks × 2).
2. pal=0, run a full frame:
   - frame_start period = 262 × 342 × 2 = 179 208 clks.
   - VS is low for lines 0-3.
   - blank=1 for lines 0-7 and for hcnt<60 or hcnt=341.
3. Toggle pal 0→1 at vcnt=100:
   - The current frame still ends at vcnt=261.
   - The next frame counts to vcnt=312 before wrapping.
   - The frame_start period becomes 214 092 clks.
4. Colour gating: drive r_i=6'h3F with g_i=b_i=0. Then:
   - R=0 whenever blank=1.
   - R=6'h3F one clk after the counters enter the active area (hcnt=60, vcnt=8).
5. ena pattern 1,0,0,1 repeating:
   - hcnt advances once per 2 ena pulses.
   - Counters hold while ena=0.
   - Assert RESET mid-line at hcnt=200: the next clk shows hcnt_o=306, vcnt_o=0, blank=1, R=0.
6. Re-elaborate with CLK_DIV=1, HS_POL=1, H_TOTAL=16, H_SYNC=2, H_ACT_START=4, H_ACT_END=14, V_TOTAL_NTSC=4, V_SYNC=1, V_BLANK=1, H_INIT=0:
   - HS is high 2 clks per 16.
   - line_start every 16 clks.
   - frame_start every 64 clks.

Source files
------------

// File: rtl/vdp_video_timing.sv
// Raster timing generator: programmable H/V counters, sync/blank regeneration and RGB blanking.
// Latency: outputs registered one clk after the counters they are derived from.
// Backpressure: none; ena paces the counters, outputs update every clk.
module vdp_video_timing #(
    parameter int CLK_DIV      = 2,
    parameter int H_TOTAL      = 342,
    parameter int H_INIT       = 306,
    parameter int H_SYNC       = 20,
    parameter int H_ACT_START  = 60,
    parameter int H_ACT_END    = 341,
    parameter int V_TOTAL_NTSC = 262,
    parameter int V_TOTAL_PAL  = 313,
    parameter int V_SYNC       = 4,
    parameter int V_BLANK      = 8,
    parameter int HS_POL       = 0,
    parameter int VS_POL       = 0,
    parameter int COLOR_W      = 6
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               ena,
    input  logic               pal,
    input  logic [COLOR_W-1:0] r_i,
    input  logic [COLOR_W-1:0] g_i,
    input  logic [COLOR_W-1:0] b_i,
    output logic               HS,
    output logic               VS,
    output logic               blank,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               line_start,
    output logic               frame_start,
    output logic [9:0]         hcnt_o,
    output logic [9:0]         vcnt_o
);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vdp_video_timing: CLK_DIV must be 1..16");
    end
    if (!(H_SYNC < H_ACT_START && H_ACT_START < H_ACT_END &&
          H_ACT_END <= H_TOTAL && H_TOTAL <= 1024)) begin : g_bad_h
        $error("vdp_video_timing: illegal horizontal timing");
    end
    if (!(V_SYNC <= V_BLANK && V_BLANK < V_TOTAL_NTSC && V_BLANK < V_TOTAL_PAL &&
          V_TOTAL_NTSC <= 1024 && V_TOTAL_PAL <= 1024)) begin : g_bad_v
        $error("vdp_video_timing: illegal vertical timing");
    end
    if (H_INIT < 0 || H_INIT >= H_TOTAL) begin : g_bad_init
        $error("vdp_video_timing: H_INIT must be below H_TOTAL");
    end

    localparam logic HS_ACT = 1'(HS_POL);
    localparam logic VS_ACT = 1'(VS_POL);

    logic [3:0] div;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       pal_q;
    logic       tick;
    logic       h_wrap;
    logic       v_wrap;
    logic       blank_c;
    logic [9:0] vtot_m1;

    assign tick    = ena && (div == 4'(CLK_DIV - 1));
    assign h_wrap  = tick && (hcnt == 10'(H_TOTAL - 1));
    // Line count is latched per frame so a frame never mixes NTSC and PAL lengths.
    assign vtot_m1 = pal_q ? 10'(V_TOTAL_PAL - 1) : 10'(V_TOTAL_NTSC - 1);
    assign v_wrap  = h_wrap && (vcnt == vtot_m1);
    assign blank_c = (vcnt < 10'(V_BLANK)) || (hcnt < 10'(H_ACT_START)) ||
                     ({1'b0, hcnt} >= 11'(H_ACT_END));

    always_ff @(posedge clk) begin
        if (RESET) begin
            div         <= '0;
            hcnt        <= 10'(H_INIT);
            vcnt        <= '0;
            pal_q       <= pal;
            HS          <= ~HS_ACT;
            VS          <= ~VS_ACT;
            blank       <= 1'b1;
            R           <= '0;
            G           <= '0;
            B           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (ena) begin
                div <= tick ? 4'd0 : div + 4'd1;
            end
            if (tick) begin
                hcnt <= h_wrap ? 10'd0 : hcnt + 10'd1;
            end
            if (h_wrap) begin
                vcnt <= v_wrap ? 10'd0 : vcnt + 10'd1;
            end
            if (v_wrap) begin
                pal_q <= pal;
            end
            // Sync/blank/colour follow the counters every clk, independent of ena.
            HS          <= (hcnt < 10'(H_SYNC)) ? HS_ACT : ~HS_ACT;
            VS          <= (vcnt < 10'(V_SYNC)) ? VS_ACT : ~VS_ACT;
            blank       <= blank_c;
            R           <= blank_c ? '0 : r_i;
            G           <= blank_c ? '0 : g_i;
            B           <= blank_c ? '0 : b_i;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

    assign hcnt_o = hcnt;
    assign vcnt_o = vcnt;

endmodule

// File: tb/tb_vdp_video_timing.sv
// Bench for vdp_video_timing: three instances (default, small-frame, tiny CLK_DIV=1 config)
// checked against a tick/line arithmetic reference model plus directed timing checks.
module tb_vdp_video_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst[3], ena[3], pal[3];
    logic [5:0] ri[3], gi[3], bi[3], ro[3], go[3], bo[3];
    logic       hs[3], vs[3], blank[3], ls[3], fs[3];
    logic [9:0] hc[3], vc[3];

    int total = 0;
    int bad   = 0;

    vdp_video_timing d0 (
        .clk(clk), .RESET(rst[0]), .ena(ena[0]), .pal(pal[0]),
        .r_i(ri[0]), .g_i(gi[0]), .b_i(bi[0]),
        .HS(hs[0]), .VS(vs[0]), .blank(blank[0]), .R(ro[0]), .G(go[0]), .B(bo[0]),
        .line_start(ls[0]), .frame_start(fs[0]), .hcnt_o(hc[0]), .vcnt_o(vc[0]));

    vdp_video_timing #(
        .CLK_DIV(3), .H_TOTAL(20), .H_INIT(5), .H_SYNC(3), .H_ACT_START(5), .H_ACT_END(18),
        .V_TOTAL_NTSC(6), .V_TOTAL_PAL(9), .V_SYNC(2), .V_BLANK(3), .HS_POL(0), .VS_POL(1)
    ) d1 (
        .clk(clk), .RESET(rst[1]), .ena(ena[1]), .pal(pal[1]),
        .r_i(ri[1]), .g_i(gi[1]), .b_i(bi[1]),
        .HS(hs[1]), .VS(vs[1]), .blank(blank[1]), .R(ro[1]), .G(go[1]), .B(bo[1]),
        .line_start(ls[1]), .frame_start(fs[1]), .hcnt_o(hc[1]), .vcnt_o(vc[1]));

    vdp_video_timing #(
        .CLK_DIV(1), .HS_POL(1), .H_TOTAL(16), .H_SYNC(2), .H_ACT_START(4), .H_ACT_END(14),
        .V_TOTAL_NTSC(4), .V_SYNC(1), .V_BLANK(1), .H_INIT(0)
    ) d2 (
        .clk(clk), .RESET(rst[2]), .ena(ena[2]), .pal(pal[2]),
        .r_i(ri[2]), .g_i(gi[2]), .b_i(bi[2]),
        .HS(hs[2]), .VS(vs[2]), .blank(blank[2]), .R(ro[2]), .G(go[2]), .B(bo[2]),
        .line_start(ls[2]), .frame_start(fs[2]), .hcnt_o(hc[2]), .vcnt_o(vc[2]));

    typedef struct {
        int   clk_div, h_total, h_init, h_sync, h_as, h_ae, vt_ntsc, vt_pal, v_sync, v_blank;
        logic hs_pol, vs_pol;
    } cfg_t;

    typedef struct {
        int         ena_cnt, lines, hcnt, vcnt;
        logic       palq, hs, vs, blank, ls, fs;
        logic [5:0] r, g, b;
    } mst_t;

    cfg_t cfg[3];
    mst_t m[3];

    // Reference: position = H_INIT + (ena pulses / CLK_DIV); line and frame follow by division.
    task automatic model_clk(input cfg_t c, input mst_t si, input logic rs, input logic en,
                             input logic pl, input logic [5:0] r, input logic [5:0] g,
                             input logic [5:0] b, output mst_t so);
        int   pos, nl, vtot;
        logic bl;
        so = si;
        if (rs) begin
            so.ena_cnt = 0; so.lines = 0; so.hcnt = c.h_init; so.vcnt = 0; so.palq = pl;
            so.hs = !c.hs_pol; so.vs = !c.vs_pol; so.blank = 1'b1;
            so.r = 0; so.g = 0; so.b = 0; so.ls = 0; so.fs = 0;
        end else begin
            bl = (si.vcnt < c.v_blank) || (si.hcnt < c.h_as) || (si.hcnt >= c.h_ae);
            so.hs = (si.hcnt < c.h_sync) ? c.hs_pol : !c.hs_pol;
            so.vs = (si.vcnt < c.v_sync) ? c.vs_pol : !c.vs_pol;
            so.blank = bl;
            so.r = bl ? 6'd0 : r;
            so.g = bl ? 6'd0 : g;
            so.b = bl ? 6'd0 : b;
            so.ls = 0; so.fs = 0;
            if (en) so.ena_cnt = si.ena_cnt + 1;
            pos = c.h_init + so.ena_cnt / c.clk_div;
            so.hcnt = pos % c.h_total;
            nl = pos / c.h_total;
            if (nl != si.lines) begin
                so.lines = nl;
                so.ls = 1;
                vtot = si.palq ? c.vt_pal : c.vt_ntsc;
                if (si.vcnt == vtot - 1) begin
                    so.vcnt = 0; so.palq = pl; so.fs = 1;
                end else begin
                    so.vcnt = si.vcnt + 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            model_clk(cfg[k], m[k], rst[k], ena[k], pal[k], ri[k], gi[k], bi[k], m[k]);
    end

    function automatic logic [42:0] exp_vec(input mst_t s);
        return {s.hs, s.vs, s.blank, s.ls, s.fs, s.r, s.g, s.b, 10'(s.hcnt), 10'(s.vcnt)};
    endfunction

    function automatic logic [42:0] dut_vec(input int k);
        return {hs[k], vs[k], blank[k], ls[k], fs[k], ro[k], go[k], bo[k], hc[k], vc[k]};
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1; ena[k] = 1; pal[k] = 0; ri[k] = 0; gi[k] = 0; bi[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (dut_vec(k) !== exp_vec(m[k])) begin
                bad++; $display("FAIL reset_model d%0d: got=%h exp=%h", k, dut_vec(k), exp_vec(m[k]));
            end
        end
        total++;
        if ({hc[0], vc[0]} !== {10'd306, 10'd0}) begin
            bad++; $display("FAIL reset_counters: got h=%0d v=%0d exp h=306 v=0", hc[0], vc[0]);
        end
        total++;
        if ({hs[0], vs[0], blank[0], ro[0], ls[0], fs[0]} !== {3'b111, 6'd0, 2'b00}) begin
            bad++; $display("FAIL reset_outputs: got hs=%b vs=%b bl=%b R=%h ls=%b fs=%b",
                            hs[0], vs[0], blank[0], ro[0], ls[0], fs[0]);
        end
        for (int k = 0; k < 3; k++) rst[k] = 0;
    endtask

    task automatic test_first_line();
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            total++;
            if (dut_vec(0) !== exp_vec(m[0])) begin
                bad++; $display("FAIL first_line_model: got=%h exp=%h", dut_vec(0), exp_vec(m[0]));
            end
            total++;
            if (hc[0] !== 10'((306 + n / 2) % 342)) begin
                bad++; $display("FAIL hcnt_step: clk %0d got=%0d exp=%0d", n, hc[0], (306 + n / 2) % 342);
            end
            ri[0] = 6'($urandom); gi[0] = 6'($urandom); bi[0] = 6'($urandom);
            if (ls[0] === 1'b1) break;
        end
        total++;
        if (n != 72 || vc[0] !== 10'd1) begin
            bad++; $display("FAIL first_line_start: got clk=%0d v=%0d exp clk=72 v=1", n, vc[0]);
        end
    endtask

    task automatic test_hsync_width();
        int low = 0;
        for (int i = 1; i <= 684; i++) begin
            @(negedge clk);
            total++;
            if (dut_vec(0) !== exp_vec(m[0])) begin
                bad++; $display("FAIL hsync_model: got=%h exp=%h", dut_vec(0), exp_vec(m[0]));
            end
            if (hs[0] === 1'b0) low++;
            if (i == 684) begin
                total++;
                if (ls[0] !== 1'b1) begin
                    bad++; $display("FAIL line_period: got ls=%b exp=1 at clk 684", ls[0]);
                end
            end
            ri[0] = 6'($urandom); gi[0] = 6'($urandom); bi[0] = 6'($urandom);
        end
        total++;
        if (low != 40) begin
            bad++; $display("FAIL hsync_width: got=%0d exp=40", low);
        end
    endtask

    task automatic test_colour_gate();
        bit armed = 0, done = 0;
        ri[0] = 6'h3F; gi[0] = 6'h00; bi[0] = 6'h00;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clk);
            total++;
            if (dut_vec(0) !== exp_vec(m[0])) begin
                bad++; $display("FAIL colour_model: got=%h exp=%h", dut_vec(0), exp_vec(m[0]));
            end
            if (blank[0] === 1'b1) begin
                total++;
                if (ro[0] !== 6'h00) begin
                    bad++; $display("FAIL colour_blanked: got R=%h exp=00", ro[0]);
                end
            end
            if (armed) begin
                total++;
                if (ro[0] !== 6'h3F || blank[0] !== 1'b0) begin
                    bad++; $display("FAIL colour_active: got R=%h bl=%b exp R=3f bl=0", ro[0], blank[0]);
                end
                done = 1;
            end else if (hc[0] == 10'd60 && vc[0] == 10'd8) begin
                armed = 1;
            end
        end
        if (!done) begin
            total++; bad++; $display("FAIL colour_timeout: active area not reached, got v=%0d exp v=8", vc[0]);
        end
    endtask

    task automatic test_ena_pattern();
        bit done = 0;
        logic last_ena;
        logic [9:0] ph, pv;
        for (int i = 0; i < 4000 && !done; i++) begin
            ena[0] = (i % 4 == 0) || (i % 4 == 3);
            last_ena = ena[0]; ph = hc[0]; pv = vc[0];
            @(negedge clk);
            total++;
            if (dut_vec(0) !== exp_vec(m[0])) begin
                bad++; $display("FAIL ena_model: got=%h exp=%h", dut_vec(0), exp_vec(m[0]));
            end
            if (!last_ena) begin
                total++;
                if (hc[0] !== ph || vc[0] !== pv) begin
                    bad++; $display("FAIL ena_hold: got h=%0d v=%0d exp h=%0d v=%0d", hc[0], vc[0], ph, pv);
                end
            end
            if (hc[0] == 10'd200) begin
                rst[0] = 1;
                @(negedge clk);
                total++;
                if ({hc[0], vc[0], blank[0], ro[0]} !== {10'd306, 10'd0, 1'b1, 6'd0}) begin
                    bad++; $display("FAIL midline_reset: got h=%0d v=%0d bl=%b R=%h exp h=306 v=0 bl=1 R=00",
                                    hc[0], vc[0], blank[0], ro[0]);
                end
                rst[0] = 0; ena[0] = 1; done = 1;
            end
        end
        if (!done) begin
            total++; bad++; $display("FAIL ena_timeout: got h=%0d exp h=200", hc[0]);
        end
    endtask

    task automatic test_frame_ntsc();
        int n = 0, vsc = 0, blc = 0, w = 0;
        while (fs[1] !== 1'b1 && w < 1000) begin
            @(negedge clk); w++;
            ri[1] = 6'($urandom); gi[1] = 6'($urandom); bi[1] = 6'($urandom);
        end
        while (n < 1000) begin
            @(negedge clk); n++;
            total++;
            if (dut_vec(1) !== exp_vec(m[1])) begin
                bad++; $display("FAIL ntsc_model: got=%h exp=%h", dut_vec(1), exp_vec(m[1]));
            end
            if (fs[1] === 1'b1) break;
            if (vs[1] === 1'b1) vsc++;
            if (blank[1] === 1'b1) blc++;
            ri[1] = 6'($urandom); gi[1] = 6'($urandom); bi[1] = 6'($urandom);
        end
        if (vs[1] === 1'b1) vsc++;
        if (blank[1] === 1'b1) blc++;
        total++;
        if (n != 360) begin bad++; $display("FAIL ntsc_period: got=%0d exp=360", n); end
        total++;
        if (vsc != 120) begin bad++; $display("FAIL ntsc_vsync: got=%0d exp=120", vsc); end
        total++;
        if (blc != 243) begin bad++; $display("FAIL ntsc_blank: got=%0d exp=243", blc); end
    endtask

    task automatic test_pal_switch();
        int exp_n[2] = '{360, 540};
        int exp_v[2] = '{5, 8};
        for (int f = 0; f < 2; f++) begin
            int n = 0, maxv = 0;
            while (n < 1000) begin
                @(negedge clk); n++;
                total++;
                if (dut_vec(1) !== exp_vec(m[1])) begin
                    bad++; $display("FAIL pal_model: got=%h exp=%h", dut_vec(1), exp_vec(m[1]));
                end
                if (fs[1] === 1'b1) break;
                if (int'(vc[1]) > maxv) maxv = int'(vc[1]);
                if (f == 0 && vc[1] == 10'd3) pal[1] = 1;
            end
            total++;
            if (n != exp_n[f] || maxv != exp_v[f]) begin
                bad++; $display("FAIL pal_frame%0d: got period=%0d maxv=%0d exp period=%0d maxv=%0d",
                                f, n, maxv, exp_n[f], exp_v[f]);
            end
        end
    endtask

    task automatic test_small_cfg();
        int w = 0, hsc = 0;
        while (fs[2] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        total++;
        if (fs[2] !== 1'b1) begin bad++; $display("FAIL small_timeout: got fs=%b exp=1", fs[2]); end
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            total++;
            if (dut_vec(2) !== exp_vec(m[2])) begin
                bad++; $display("FAIL small_model: got=%h exp=%h", dut_vec(2), exp_vec(m[2]));
            end
            total++;
            if (ls[2] !== (i % 16 == 0) || fs[2] !== (i == 64)) begin
                bad++; $display("FAIL small_strobes: clk %0d got ls=%b fs=%b exp ls=%b fs=%b",
                                i, ls[2], fs[2], (i % 16 == 0), (i == 64));
            end
            if (hs[2] === 1'b1) hsc++;
        end
        total++;
        if (hsc != 8) begin bad++; $display("FAIL small_hsync: got=%0d exp=8", hsc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            ena[1] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) pal[1] = ~pal[1];
            rst[1] = ($urandom_range(0, 499) == 0);
            ri[1] = 6'($urandom); gi[1] = 6'($urandom); bi[1] = 6'($urandom);
            @(negedge clk);
            total++;
            if (dut_vec(1) !== exp_vec(m[1])) begin
                bad++; $display("FAIL random_model: step %0d got=%h exp=%h", i, dut_vec(1), exp_vec(m[1]));
            end
            total++;
            if (hc[1] >= 10'd20 || vc[1] >= 10'd9) begin
                bad++; $display("FAIL random_range: got h=%0d v=%0d exp h<20 v<9", hc[1], vc[1]);
            end
        end
        rst[1] = 0;
    endtask

    initial begin
        cfg[0] = '{2, 342, 306, 20, 60, 341, 262, 313, 4, 8, 1'b0, 1'b0};
        cfg[1] = '{3, 20, 5, 3, 5, 18, 6, 9, 2, 3, 1'b0, 1'b1};
        cfg[2] = '{1, 16, 0, 2, 4, 14, 4, 313, 1, 1, 1'b1, 1'b0};
        test_reset();
        test_first_line();
        test_hsync_width();
        test_colour_gate();
        test_ena_pattern();
        test_frame_ntsc();
        test_pal_switch();
        test_small_cfg();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
